// File: rtl/memory_map_ctrl.sv
// CPU data-port controller: RAM / screen / keyboard decode with a one-cycle registered read.
// Define MEMORY_MAP_KBD_FIFO_EN for a KBD_DEPTH-entry key FIFO; otherwise a single KEY register is used.
module memory_map_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int RAM_AW    = 14,
  parameter int SCR_AW    = 13,
  parameter int KBD_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic              kbd_overflow
);

  localparam int OFF_W = ADDR_W - 2;

  if (KBD_DEPTH < 2 || (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("KBD_DEPTH must be a power of two >= 2");
  end
  if (ADDR_W < RAM_AW + 1 || ADDR_W < SCR_AW + 2 || DATA_W < 16) begin : g_bad_widths
    $error("address/data widths too small for the memory map");
  end

  logic [1:0]       region;
  logic [OFF_W-1:0] offset;
  logic             rd;
  logic             wr;
  logic             is_ram;
  logic             is_scr;
  logic             is_kbd;
  logic             rd_key;
  logic             rd_status;

  assign region    = address[ADDR_W-1 -: 2];
  assign offset    = address[OFF_W-1:0];
  assign rd        = req & ~write;
  assign wr        = req & write;
  assign is_ram    = ~region[1];
  assign is_scr    = (region == 2'b10);
  assign is_kbd    = (region == 2'b11);
  assign rd_key    = rd & is_kbd & (offset == '0);
  assign rd_status = rd & is_kbd & (offset == OFF_W'(1));

  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] scr [2**SCR_AW];

  always_ff @(posedge clock) begin
    if (wr && is_ram) ram[address[RAM_AW-1:0]] <= in;
  end

  always_ff @(posedge clock) begin
    if (wr && is_scr) scr[address[SCR_AW-1:0]] <= in;
  end

  logic [DATA_W-1:0] key_word;
  logic [7:0]        key_count;
  logic              ovf_set;

`ifdef MEMORY_MAP_KBD_FIFO_EN
  localparam int PTR_W = $clog2(KBD_DEPTH);
  localparam int CNT_W = $clog2(KBD_DEPTH + 1);

  logic [DATA_W-1:0] fifo [KBD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Ready comes from registered fullness only, so a same-cycle pop at full cannot raise it.
  assign full      = (count == CNT_W'(KBD_DEPTH));
  assign empty     = (count == '0);
  assign kbd_ready = ~full;
  assign push      = kbd_valid & ~full;
  assign pop       = rd_key & ~empty;
  assign ovf_set   = kbd_valid & full;
  assign key_word  = empty ? '0 : fifo[rd_ptr];
  assign key_count = 8'(count);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= kbd_data;
  end
`else
  logic [DATA_W-1:0] key_reg;
  logic              key_fresh;

  // A KEY read in the same cycle as a new key consumes the old one, so nothing is lost.
  assign kbd_ready = 1'b1;
  assign ovf_set   = kbd_valid & key_fresh & (key_reg != '0) & ~rd_key;
  assign key_word  = key_reg;
  assign key_count = {7'b0, (key_reg != '0)};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_reg   <= '0;
      key_fresh <= 1'b0;
    end else begin
      if (kbd_valid) begin
        key_reg   <= kbd_data;
        key_fresh <= 1'b1;
      end else if (rd_key) begin
        key_fresh <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       kbd_overflow <= 1'b0;
    else if (ovf_set)   kbd_overflow <= 1'b1;
    else if (rd_status) kbd_overflow <= 1'b0;
  end

  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_word_p0;

  always_comb begin
    status_word      = '0;
    status_word[7:0] = key_count;
    status_word[15]  = kbd_overflow;
  end

  always_comb begin
    rd_word_p0 = '0;
    if (is_ram)      rd_word_p0 = ram[address[RAM_AW-1:0]];
    else if (is_scr) rd_word_p0 = scr[address[SCR_AW-1:0]];
    else if (offset == '0)         rd_word_p0 = key_word;
    else if (offset == OFF_W'(1))  rd_word_p0 = status_word;
  end

  // ---- stage p0 -> p1: registered read data ----
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd;
      if (rd) rd_data_p1 <= rd_word_p0;
    end
  end

  assign out       = rd_data_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_memory_map_ctrl.sv
// Scoreboard bench for memory_map_ctrl: a memory-map reference model predicts each read,
// a monitor compares whenever out_valid pulses.
module tb_memory_map_ctrl;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 15;
  localparam int RAM_AW    = 14;
  localparam int SCR_AW    = 13;
  localparam int KBD_DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              req = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] in = '0;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic [DATA_W-1:0] kbd_data = '0;
  logic              kbd_valid = 1'b0;
  logic              kbd_ready;
  logic              kbd_overflow;

  memory_map_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .SCR_AW(SCR_AW), .KBD_DEPTH(KBD_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .write(write), .address(address), .in(in),
    .out(out), .out_valid(out_valid), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]  val;
    logic [14:0]  addr;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [15:0] kq[$];
  logic        ov_m = 1'b0;
  logic [15:0] key_m = '0;
  logic        fresh_m = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [15:0] last_out = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int key_cnt();
`ifdef MEMORY_MAP_KBD_FIFO_EN
    return kq.size();
`else
    return (key_m != 0) ? 1 : 0;
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [14:0] a);
    logic [7:0] c8;
    case (a[14:13])
      2'b00, 2'b01: return ram_m.exists(int'(a[13:0])) ? ram_m[int'(a[13:0])] : 16'h0;
      2'b10:        return scr_m.exists(int'(a[12:0])) ? scr_m[int'(a[12:0])] : 16'h0;
      default: begin
        if (a[12:0] == 13'd0) begin
`ifdef MEMORY_MAP_KBD_FIFO_EN
          return (kq.size() > 0) ? kq[0] : 16'h0;
`else
          return key_m;
`endif
        end
        if (a[12:0] == 13'd1) begin
          c8 = 8'(key_cnt());
          return {ov_m, 7'b0, c8};
        end
        return 16'h0;
      end
    endcase
  endfunction

  // One bus cycle: check pre-edge flags, queue expected read, advance the model.
  task automatic do_cycle(input logic r, input logic w, input logic [14:0] a, input logic [15:0] d,
                          input logic kv, input logic [15:0] kd, input logic use_c, input logic [15:0] cexp);
    logic rd, rdkey, rdst, ovs;
    req = r; write = w; address = a; in = d; kbd_valid = kv; kbd_data = kd;
`ifdef MEMORY_MAP_KBD_FIFO_EN
    check("kbd_ready", kbd_ready, (kq.size() < KBD_DEPTH) ? 1 : 0);
`else
    check("kbd_ready", kbd_ready, 1);
`endif
    check("kbd_overflow", kbd_overflow, ov_m);
    rd    = r && !w;
    rdkey = rd && a[14:13] == 2'b11 && a[12:0] == 13'd0;
    rdst  = rd && a[14:13] == 2'b11 && a[12:0] == 13'd1;
    if (rd) sb.push_back('{use_c ? cexp : model_read(a), a, cyc});
`ifdef MEMORY_MAP_KBD_FIFO_EN
    ovs = kv && kq.size() >= KBD_DEPTH;
    begin
      bit do_push;
      do_push = kv && kq.size() < KBD_DEPTH;
      if (rdkey && kq.size() > 0) void'(kq.pop_front());
      if (do_push) kq.push_back(kd);
    end
`else
    ovs = kv && key_m != 0 && fresh_m && !rdkey;
    if (kv) begin
      key_m = kd;
      fresh_m = 1'b1;
    end else if (rdkey) begin
      fresh_m = 1'b0;
    end
`endif
    if (ovs) ov_m = 1'b1;
    else if (rdst) ov_m = 1'b0;
    if (r && w) begin
      if (!a[14]) ram_m[int'(a[13:0])] = d;
      else if (a[14:13] == 2'b10) scr_m[int'(a[12:0])] = d;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d); do_cycle(1, 1, a, d, 0, 0, 0, 0); endtask
  task automatic rdc(input logic [14:0] a, input logic [15:0] v); do_cycle(1, 0, a, 0, 0, 0, 1, v); endtask
  task automatic rdm(input logic [14:0] a); do_cycle(1, 0, a, 0, 0, 0, 0, 0); endtask
  task automatic key(input logic [15:0] kd); do_cycle(0, 0, 0, 0, 1, kd, 0, 0); endtask
  task automatic idle(); do_cycle(0, 0, 0, 0, 0, 0, 0, 0); endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      last_out = '0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got out=0x%0h expected no read result", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("read_latency@%0h", e.addr), cyc, e.cyc + 1);
        check($sformatf("read_data@%0h", e.addr), out, e.val);
      end
      last_out = out;
    end else begin
      check("out_hold", out, last_out);
    end
  end

  task automatic reset_mid_read();
    req = 1; write = 0; address = 15'h6000; in = 0; kbd_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_kbd_overflow", kbd_overflow, 0);
    check("rst_kbd_ready", kbd_ready, 1);
    kq.delete();
    ov_m = 1'b0; key_m = '0; fresh_m = 1'b0;
    @(posedge clock);
    #1 req = 0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    check("post_rst_out", out, 0);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clock);
    #1;
    check("post_rst_no_valid", out_valid, 0);
    check("post_rst_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #11;
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_kbd_overflow", kbd_overflow, 0);
    check("reset_kbd_ready", kbd_ready, 1);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    wr(15'h0005, 16'h1234);
    wr(15'h4003, 16'hBEEF);
    rdc(15'h0005, 16'h1234);
    rdc(15'h4003, 16'hBEEF);
    wr(15'h2005, 16'h5A5A);
    rdc(15'h2005, 16'h5A5A);
    rdc(15'h0005, 16'h1234);
    wr(15'h6000, 16'hFFFF);
    rdc(15'h6000, 16'h0000);
    rdc(15'h6002, 16'h0000);

`ifdef MEMORY_MAP_KBD_FIFO_EN
    key(16'h41); key(16'h42); key(16'h43);
    rdc(15'h6001, 16'h0003);
    rdc(15'h6000, 16'h0041);
    rdc(15'h6000, 16'h0042);
    rdc(15'h6000, 16'h0043);
    rdc(15'h6000, 16'h0000);
    rdc(15'h6001, 16'h0000);

    key(16'h71); key(16'h72); idle();
    reset_mid_read();
    rdc(15'h6001, 16'h0000);
    rdc(15'h6000, 16'h0000);
    rdc(15'h0005, 16'h1234);

    key(16'h51); key(16'h52); key(16'h53); key(16'h54);
    check("ready_low_at_full", kbd_ready, 0);
    key(16'h55);
    rdc(15'h6001, 16'h8004);
    rdc(15'h6001, 16'h0004);
    rdc(15'h6000, 16'h0051);
    rdc(15'h6000, 16'h0052);
    do_cycle(1, 0, 15'h6000, 0, 1, 16'h60, 1, 16'h0053);
    rdc(15'h6001, 16'h0002);
    rdc(15'h6000, 16'h0054);
    rdc(15'h6000, 16'h0060);
`else
    key(16'h41); key(16'h42);
    rdc(15'h6000, 16'h0042);
    rdc(15'h6001, 16'h8001);
    key(16'h00);
    rdc(15'h6001, 16'h0000);

    key(16'h71); idle();
    reset_mid_read();
    rdc(15'h6001, 16'h0000);
    rdc(15'h6000, 16'h0000);
    rdc(15'h0005, 16'h1234);
`endif

    for (int i = 0; i < 8; i++) begin
      wr(15'(i), 16'($urandom));
      wr(15'(16'h2000 + i), 16'($urandom));
      wr(15'(16'h4000 + i), 16'($urandom));
    end

    for (int i = 0; i < 400; i++) begin
      logic [14:0] a;
      logic        r, w, kv;
      int          sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 15'(($urandom_range(0, 1) << 13) | $urandom_range(0, 7));
        1:       a = 15'(16'h4000 | $urandom_range(0, 7));
        default: a = 15'(16'h6000 | $urandom_range(0, 2));
      endcase
      r  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      kv = ($urandom_range(0, 2) == 0);
      do_cycle(r, w, a, 16'($urandom), kv, 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 0, 0);
    end

    idle(); idle(); idle();
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
